// File: rtl/relobi_pkg.sv
// Shared types for the triplicated OBI response path: R-channel beat layout,
// triplicated FIFO control state and the fan-out FIFO depth.
package relobi_pkg;

  localparam int unsigned RDataW       = 32;
  localparam int unsigned RDataEccW    = 7;
  localparam int unsigned RIdW         = 4;
  localparam int unsigned ROptW        = 1;
  localparam int unsigned ROtherEccW   = 6;
  localparam int unsigned RFanoutDepth = 2;

  typedef logic [ROptW-1:0] r_optional_t;

  typedef struct packed {
    logic [RDataW+RDataEccW-1:0] rdata;
    logic [RIdW-1:0]             rid;
    logic                        err;
    r_optional_t                 r_optional;
    logic [ROtherEccW-1:0]       other_ecc;
  } obi_r_chan_t;

  localparam int unsigned RChanW = $bits(obi_r_chan_t);

  typedef struct packed {
    logic       wptr;
    logic       rptr;
    logic [1:0] cnt;
  } tmr_r_state_t;

endpackage

// File: rtl/TMR_voter_fail.sv
// Single-bit majority voter; flags when the three inputs are not all equal.
module TMR_voter_fail (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic majority_o,
  output logic fault_detected_o
);

  assign majority_o       = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  assign fault_detected_o = (a_i ^ b_i) | (a_i ^ c_i);

endmodule

// File: rtl/bitwise_TMR_voter_fail.sv
// Per-bit majority voter over three copies; flags any bit where the copies differ.
module bitwise_TMR_voter_fail #(
  parameter int unsigned DataWidth = 1
) (
  input  logic [DataWidth-1:0] a_i,
  input  logic [DataWidth-1:0] b_i,
  input  logic [DataWidth-1:0] c_i,
  output logic [DataWidth-1:0] majority_o,
  output logic                 fault_detected_o
);

  assign majority_o       = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
  assign fault_detected_o = |((a_i ^ b_i) | (a_i ^ c_i));

endmodule

// File: rtl/relobi_tmr_r_fanout.sv
// Fans one OBI R beat out to three redundant manager replicas through a 2-entry
// triple-stored FIFO whose control state is triplicated and re-voted every cycle.
module relobi_tmr_r_fanout
  import relobi_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [RChanW-1:0]     r_i,
  input  logic                  rvalid_i,
  output logic                  rready_o,
  output logic [3*RChanW-1:0]   three_r_o,
  output logic [2:0]            three_rvalid_o,
  input  logic [2:0]            three_rready_i,
  output logic                  fault_o,
  output logic [7:0]            fault_cnt_o
);

  tmr_r_state_t state_a_q, state_b_q, state_c_q;
  tmr_r_state_t state_v, state_d;
  tmr_r_state_t st [3];
  logic         state_fault;
  logic         ready_v, ready_fault;
  logic         push, pop;
  logic [RChanW-1:0] mem_q [3][RFanoutDepth];
  logic [7:0]   fault_cnt_q;

  assign st[0] = state_a_q;
  assign st[1] = state_b_q;
  assign st[2] = state_c_q;

  bitwise_TMR_voter_fail #(
    .DataWidth($bits(tmr_r_state_t))
  ) i_state_voter (
    .a_i              (state_a_q),
    .b_i              (state_b_q),
    .c_i              (state_c_q),
    .majority_o       (state_v),
    .fault_detected_o (state_fault)
  );

  TMR_voter_fail i_ready_voter (
    .a_i              (three_rready_i[0]),
    .b_i              (three_rready_i[1]),
    .c_i              (three_rready_i[2]),
    .majority_o       (ready_v),
    .fault_detected_o (ready_fault)
  );

  // rready_o depends only on registered state, so a pop never re-opens it combinationally
  assign rready_o = (state_v.cnt < 2'(RFanoutDepth));
  assign push     = rvalid_i & rready_o;
  assign pop      = (state_v.cnt != 2'd0) & ready_v;

  always_comb begin
    state_d      = state_v;
    state_d.wptr = state_v.wptr ^ push;
    state_d.rptr = state_v.rptr ^ pop;
    state_d.cnt  = state_v.cnt + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_a_q <= '0;
      state_b_q <= '0;
      state_c_q <= '0;
    end else begin
      state_a_q <= state_d;
      state_b_q <= state_d;
      state_c_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < 3; k++) begin
        for (int e = 0; e < int'(RFanoutDepth); e++) begin
          mem_q[k][e] <= '0;
        end
      end
    end else if (push) begin
      for (int k = 0; k < 3; k++) begin
        mem_q[k][state_v.wptr] <= r_i;
      end
    end
  end

  // Each replica is driven purely from its own state and storage copy
  always_comb begin
    three_rvalid_o = '0;
    three_r_o      = '0;
    for (int k = 0; k < 3; k++) begin
      three_rvalid_o[k]              = (st[k].cnt != 2'd0);
      three_r_o[k*RChanW +: RChanW]  = mem_q[k][st[k].rptr];
    end
  end

  assign fault_o = state_fault | ((state_v.cnt != 2'd0) & ready_fault);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fault_cnt_q <= '0;
    end else if (fault_o && (fault_cnt_q != 8'hFF)) begin
      fault_cnt_q <= fault_cnt_q + 8'd1;
    end
  end

  assign fault_cnt_o = fault_cnt_q;

endmodule

// File: tb/tb_relobi_tmr_r_fanout.sv
// Randomized and directed bench for relobi_tmr_r_fanout against a queue-based model.
module tb_relobi_tmr_r_fanout;
  import relobi_pkg::*;

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b1;
  logic [RChanW-1:0]   r_i = '0;
  logic                rvalid_i = 1'b0;
  logic                rready_o;
  logic [3*RChanW-1:0] three_r_o;
  logic [2:0]          three_rvalid_o;
  logic [2:0]          three_rready_i = 3'b000;
  logic                fault_o;
  logic [7:0]          fault_cnt_o;

  relobi_tmr_r_fanout dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .r_i            (r_i),
    .rvalid_i       (rvalid_i),
    .rready_o       (rready_o),
    .three_r_o      (three_r_o),
    .three_rvalid_o (three_rvalid_o),
    .three_rready_i (three_rready_i),
    .fault_o        (fault_o),
    .fault_cnt_o    (fault_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_bad = 0;
  logic [RChanW-1:0] q[$];
  int fcnt_m = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; outputs are compared before the edge, then the model advances.
  task automatic cycle(input logic v, input logic [RChanW-1:0] r, input logic [2:0] rdy);
    int  ones;
    bit  exp_fault, acc, popd;
    @(negedge clk_i);
    rvalid_i = v;
    r_i = r;
    three_rready_i = rdy;
    #1;
    ones = int'(rdy[0]) + int'(rdy[1]) + int'(rdy[2]);
    exp_fault = (q.size() != 0) && (rdy != 3'b000) && (rdy != 3'b111);
    chk("rready", 64'(rready_o), 64'(q.size() < 2));
    chk("rvalid", 64'(three_rvalid_o), (q.size() != 0) ? 64'h7 : 64'h0);
    if (q.size() != 0) begin
      for (int k = 0; k < 3; k++) chk("rdata", 64'(three_r_o[k*RChanW +: RChanW]), 64'(q[0]));
    end
    chk("fault", 64'(fault_o), 64'(exp_fault));
    chk("fault_cnt", 64'(fault_cnt_o), 64'(fcnt_m));
    acc  = v && (q.size() < 2);
    popd = (q.size() != 0) && (ones >= 2);
    @(posedge clk_i);
    if (popd) void'(q.pop_front());
    if (acc) q.push_back(r);
    if (exp_fault && fcnt_m < 255) fcnt_m++;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rvalid_i = 1'b0;
    three_rready_i = 3'b000;
    rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    q.delete();
    fcnt_m = 0;
  endtask

  function automatic logic [RChanW-1:0] rnd_beat();
    return RChanW'({$urandom, $urandom});
  endfunction

  initial begin
    obi_r_chan_t  b;
    tmr_r_state_t up;
    logic [RChanW-1:0] beats [3];
    logic [2:0] rdy;
    int sel;

    // reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("rst_rvalid", 64'(three_rvalid_o), 64'h0);
    chk("rst_rready", 64'(rready_o), 64'h1);
    chk("rst_r", 64'(three_r_o[63:0]), 64'h0);
    chk("rst_fcnt", 64'(fault_cnt_o), 64'h0);
    chk("rst_fault", 64'(fault_o), 64'h0);

    // single beat, all replicas ready
    b = '0;
    b.rid = 4'd3;
    b.rdata = 39'hDEADBEEF;
    cycle(1'b1, b, 3'b111);
    cycle(1'b0, '0, 3'b111);
    cycle(1'b0, '0, 3'b111);

    // back-pressure to full, then in-order drain; third accepted after first pop
    for (int i = 0; i < 3; i++) beats[i] = rnd_beat();
    cycle(1'b1, beats[0], 3'b000);
    cycle(1'b1, beats[1], 3'b000);
    cycle(1'b1, beats[2], 3'b000);
    cycle(1'b1, beats[2], 3'b111);
    cycle(1'b1, beats[2], 3'b111);
    cycle(1'b0, '0, 3'b111);
    cycle(1'b0, '0, 3'b111);

    // outvoted ready
    do_reset();
    cycle(1'b1, rnd_beat(), 3'b000);
    cycle(1'b0, '0, 3'b011);
    cycle(1'b0, '0, 3'b000);
    chk("outvote_cnt", 64'(fault_cnt_o), 64'h1);

    // reset mid-operation with two entries held
    cycle(1'b1, rnd_beat(), 3'b000);
    cycle(1'b1, rnd_beat(), 3'b000);
    @(negedge clk_i);
    rvalid_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    chk("async_rvalid", 64'(three_rvalid_o), 64'h0);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    q.delete();
    fcnt_m = 0;
    #1;
    chk("rel_rready", 64'(rready_o), 64'h1);
    chk("rel_fcnt", 64'(fault_cnt_o), 64'h0);

    // single-copy state upset while empty
    @(negedge clk_i);
    three_rready_i = 3'b000;
    up = '0;
    up.cnt = 2'd2;
    force dut.state_c_q = up;
    #1;
    chk("upset_fault", 64'(fault_o), 64'h1);
    chk("upset_rvalid", 64'(three_rvalid_o), 64'h4);
    release dut.state_c_q;
    @(posedge clk_i);
    fcnt_m++;
    @(negedge clk_i);
    #1;
    chk("upset_fixed", 64'(dut.state_c_q.cnt), 64'h0);
    chk("upset_clear", 64'(fault_o), 64'h0);
    cycle(1'b0, '0, 3'b000);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) rdy = 3'b111;
      else if (sel < 6) rdy = 3'b000;
      else rdy = 3'($urandom);
      cycle(1'($urandom), rnd_beat(), rdy);
    end

    // saturation of the fault counter
    do_reset();
    cycle(1'b1, rnd_beat(), 3'b000);
    for (int i = 0; i < 300; i++) cycle(1'b0, '0, 3'b001);
    @(negedge clk_i);
    #1;
    chk("sat_cnt", 64'(fault_cnt_o), 64'd255);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
